// File: rtl/drc_sram_array.sv
// DRC set-associative tag/data/meta store: 1-cycle all-way reads, single-way writes, no backpressure;
// post-reset sweep clears valid bits. Define DRC_SRAM_BYPASS_EN for same-set write-to-read forwarding.
module drc_sram_array #(
  parameter int N_WAY    = 4,
  parameter int IDX_SIZE = 4,
  parameter int TAG_SIZE = 20,
  parameter int DATA_W   = 272,
  parameter int SYN_W    = 32,
  parameter int CNT_W    = 8,
  localparam int WAY_WIDTH = $clog2(N_WAY)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rden_i,
  input  logic [IDX_SIZE-1:0]       raddr_i,
  output logic [N_WAY-1:0]          rdata_valid_o,
  output logic [N_WAY*TAG_SIZE-1:0] rdata_tag_o,
  output logic [N_WAY*DATA_W-1:0]   rdata_data_o,
  output logic [N_WAY*2-1:0]        rdata_type_o,
  output logic [N_WAY*SYN_W-1:0]    rdata_syn_o,
  output logic [N_WAY*CNT_W-1:0]    rdata_cnt_o,
  input  logic                      wren_i,
  input  logic [IDX_SIZE-1:0]       waddr_i,
  input  logic [WAY_WIDTH-1:0]      wway_i,
  input  logic                      wvalid_i,
  input  logic [TAG_SIZE-1:0]       wtag_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [1:0]                wtype_i,
  input  logic [SYN_W-1:0]          wsyn_i,
  input  logic [CNT_W-1:0]          wcnt_i,
  output logic                      init_busy_o
);

  localparam int SETS = 2**IDX_SIZE;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              state_q, state_d;
  logic [IDX_SIZE-1:0] ptr_q;
  logic                sweep_en;
  logic                wr_fire;

  logic [N_WAY-1:0]                valid_q  [SETS];
  logic [N_WAY-1:0][TAG_SIZE-1:0]  tag_mem  [SETS];
  logic [N_WAY-1:0][DATA_W-1:0]    data_mem [SETS];
  logic [N_WAY-1:0][1:0]           type_mem [SETS];
  logic [N_WAY-1:0][SYN_W-1:0]     syn_mem  [SETS];
  logic [N_WAY-1:0][CNT_W-1:0]     cnt_mem  [SETS];

  logic [N_WAY-1:0]               rd_valid;
  logic [N_WAY-1:0][TAG_SIZE-1:0] rd_tag;
  logic [N_WAY-1:0][DATA_W-1:0]   rd_data;
  logic [N_WAY-1:0][1:0]          rd_type;
  logic [N_WAY-1:0][SYN_W-1:0]    rd_syn;
  logic [N_WAY-1:0][CNT_W-1:0]    rd_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && ptr_q == IDX_SIZE'(SETS - 1))
      state_d = S_READY;
  end

  // Writes are gated by rst_n so a reset edge never lands traffic.
  always_comb begin
    init_busy_o = (state_q == S_INIT);
    sweep_en    = (state_q == S_INIT);
    wr_fire     = (state_q == S_READY) && wren_i && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        ptr_q <= '0;
    else if (sweep_en) ptr_q <= ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sweep_en)     valid_q[ptr_q] <= '0;
    else if (wr_fire) valid_q[waddr_i][wway_i] <= wvalid_i;
  end

  // Payload fields have no reset so they can map onto a 1R1W macro.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      tag_mem[waddr_i][wway_i]  <= wtag_i;
      data_mem[waddr_i][wway_i] <= wdata_i;
      type_mem[waddr_i][wway_i] <= wtype_i;
      syn_mem[waddr_i][wway_i]  <= wsyn_i;
      cnt_mem[waddr_i][wway_i]  <= wcnt_i;
    end
  end

  always_comb begin
    rd_valid = valid_q[raddr_i];
    rd_tag   = tag_mem[raddr_i];
    rd_data  = data_mem[raddr_i];
    rd_type  = type_mem[raddr_i];
    rd_syn   = syn_mem[raddr_i];
    rd_cnt   = cnt_mem[raddr_i];
`ifdef DRC_SRAM_BYPASS_EN
    if (wr_fire && raddr_i == waddr_i) begin
      rd_valid[wway_i] = wvalid_i;
      rd_tag[wway_i]   = wtag_i;
      rd_data[wway_i]  = wdata_i;
      rd_type[wway_i]  = wtype_i;
      rd_syn[wway_i]   = wsyn_i;
      rd_cnt[wway_i]   = wcnt_i;
    end
`endif
  end

  // Outputs hold between reads; the consumer samples only on a hit.
  always_ff @(posedge clk) begin
    if (!rst_n || (rden_i && state_q == S_INIT)) begin
      rdata_valid_o <= '0;
      rdata_tag_o   <= '0;
      rdata_data_o  <= '0;
      rdata_type_o  <= '0;
      rdata_syn_o   <= '0;
      rdata_cnt_o   <= '0;
    end else if (rden_i) begin
      rdata_valid_o <= rd_valid;
      rdata_tag_o   <= rd_tag;
      rdata_data_o  <= rd_data;
      rdata_type_o  <= rd_type;
      rdata_syn_o   <= rd_syn;
      rdata_cnt_o   <= rd_cnt;
    end
  end

endmodule

// File: tb/tb_drc_sram_array.sv
// Directed bench for drc_sram_array: reset sweep, write/read, invalidate, same-cycle collision, INIT drops.
module tb_drc_sram_array;

  localparam int N_WAY = 4, IDX_SIZE = 4, TAG_SIZE = 20, DATA_W = 272, SYN_W = 32, CNT_W = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      rden_i;
  logic [IDX_SIZE-1:0]       raddr_i;
  logic [N_WAY-1:0]          rdata_valid_o;
  logic [N_WAY*TAG_SIZE-1:0] rdata_tag_o;
  logic [N_WAY*DATA_W-1:0]   rdata_data_o;
  logic [N_WAY*2-1:0]        rdata_type_o;
  logic [N_WAY*SYN_W-1:0]    rdata_syn_o;
  logic [N_WAY*CNT_W-1:0]    rdata_cnt_o;
  logic                      wren_i;
  logic [IDX_SIZE-1:0]       waddr_i;
  logic [1:0]                wway_i;
  logic                      wvalid_i;
  logic [TAG_SIZE-1:0]       wtag_i;
  logic [DATA_W-1:0]         wdata_i;
  logic [1:0]                wtype_i;
  logic [SYN_W-1:0]          wsyn_i;
  logic [CNT_W-1:0]          wcnt_i;
  logic                      init_busy_o;

  int checks = 0;
  int errors = 0;

  drc_sram_array dut (
    .clk(clk), .rst_n(rst_n),
    .rden_i(rden_i), .raddr_i(raddr_i),
    .rdata_valid_o(rdata_valid_o), .rdata_tag_o(rdata_tag_o), .rdata_data_o(rdata_data_o),
    .rdata_type_o(rdata_type_o), .rdata_syn_o(rdata_syn_o), .rdata_cnt_o(rdata_cnt_o),
    .wren_i(wren_i), .waddr_i(waddr_i), .wway_i(wway_i), .wvalid_i(wvalid_i),
    .wtag_i(wtag_i), .wdata_i(wdata_i), .wtype_i(wtype_i), .wsyn_i(wsyn_i), .wcnt_i(wcnt_i),
    .init_busy_o(init_busy_o)
  );

  always #5 clk = ~clk;

  // All drive tasks start and end just after a falling edge.
  task automatic set_write(input logic [3:0] a, input logic [1:0] w, input logic v,
                           input logic [19:0] t, input logic [271:0] d, input logic [7:0] c);
    wren_i = 1'b1; waddr_i = a; wway_i = w; wvalid_i = v;
    wtag_i = t; wdata_i = d; wtype_i = 2'b10; wsyn_i = 32'hC0DE_0000 | 32'(a); wcnt_i = c;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [1:0] w, input logic v,
                          input logic [19:0] t, input logic [271:0] d, input logic [7:0] c);
    set_write(a, w, v, t, d, c);
    @(negedge clk);
    wren_i = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    rden_i = 1'b1; raddr_i = a;
    @(negedge clk);
    rden_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (init_busy_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    pulse_reset();
    checks++;
    if (rdata_valid_o !== 4'b0000 || rdata_tag_o !== '0 || rdata_data_o !== '0 || rdata_cnt_o !== '0) begin
      errors++; $display("FAIL reset_rdata: valid=%b tag=%h cnt=%h want all zero", rdata_valid_o, rdata_tag_o, rdata_cnt_o);
    end
    checks++;
    if (init_busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", init_busy_o);
    end
    wait_ready(n);
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL sweep_len: busy for %0d cycles want 16", n);
    end
    for (int s = 0; s < 16; s++) begin
      do_read(4'(s));
      checks++;
      if (rdata_valid_o !== 4'b0000) begin
        errors++; $display("FAIL post_sweep_valid set %0d: got %b want 0000", s, rdata_valid_o);
      end
    end
  endtask

  task automatic test_write_read();
    logic [271:0] d = {17{16'h1234}};
    do_write(4'd3, 2'd2, 1'b1, 20'hABCDE, d, 8'd5);
    do_read(4'd3);
    checks++;
    if (rdata_valid_o !== 4'b0100) begin
      errors++; $display("FAIL wr_rd_valid: got %b want 0100", rdata_valid_o);
    end
    checks++;
    if (rdata_tag_o[2*20 +: 20] !== 20'hABCDE) begin
      errors++; $display("FAIL wr_rd_tag: got %h want abcde", rdata_tag_o[2*20 +: 20]);
    end
    checks++;
    if (rdata_data_o[2*272 +: 272] !== d) begin
      errors++; $display("FAIL wr_rd_data: got %h want %h", rdata_data_o[2*272 +: 272], d);
    end
    checks++;
    if (rdata_cnt_o[2*8 +: 8] !== 8'd5 || rdata_type_o[2*2 +: 2] !== 2'b10 || rdata_syn_o[2*32 +: 32] !== 32'hC0DE_0003) begin
      errors++; $display("FAIL wr_rd_meta: cnt=%h type=%b syn=%h want 05 10 c0de0003",
                         rdata_cnt_o[2*8 +: 8], rdata_type_o[2*2 +: 2], rdata_syn_o[2*32 +: 32]);
    end
    // Outputs must hold while no read is issued.
    do_read(4'd0);
    do_write(4'd0, 2'd3, 1'b1, 20'h0F0F0, '0, 8'd1);
    repeat (2) @(negedge clk);
    checks++;
    if (rdata_valid_o !== 4'b0000) begin
      errors++; $display("FAIL hold_no_read: got %b want 0000", rdata_valid_o);
    end
  endtask

  task automatic test_invalidate();
    do_write(4'd4, 2'd0, 1'b1, 20'h44444, '1, 8'd9);
    do_write(4'd3, 2'd2, 1'b0, 20'h12345, '0, 8'd0);
    do_read(4'd3);
    checks++;
    if (rdata_valid_o !== 4'b0000) begin
      errors++; $display("FAIL inval_valid: got %b want 0000", rdata_valid_o);
    end
    checks++;
    if (rdata_tag_o[2*20 +: 20] !== 20'h12345) begin
      errors++; $display("FAIL inval_tag_stored: got %h want 12345", rdata_tag_o[2*20 +: 20]);
    end
    do_read(4'd4);
    checks++;
    if (rdata_valid_o !== 4'b0001 || rdata_tag_o[19:0] !== 20'h44444) begin
      errors++; $display("FAIL other_set: valid=%b tag=%h want 0001 44444", rdata_valid_o, rdata_tag_o[19:0]);
    end
    do_read(4'd0);
    checks++;
    if (rdata_valid_o !== 4'b1000 || rdata_tag_o[3*20 +: 20] !== 20'h0F0F0) begin
      errors++; $display("FAIL set0_way3: valid=%b tag=%h want 1000 0f0f0", rdata_valid_o, rdata_tag_o[3*20 +: 20]);
    end
  endtask

  task automatic test_collision();
    logic [3:0] exp_v;
    logic [19:0] exp_t;
    do_write(4'd7, 2'd3, 1'b1, 20'h33333, '0, 8'd3);
    do_write(4'd7, 2'd1, 1'b0, 20'h22222, '0, 8'd2);
    set_write(4'd7, 2'd1, 1'b1, 20'h11111, '0, 8'd1);
    do_read(4'd7);
    wren_i = 1'b0;
`ifdef DRC_SRAM_BYPASS_EN
    exp_v = 4'b1010; exp_t = 20'h11111;
`else
    exp_v = 4'b1000; exp_t = 20'h22222;
`endif
    checks++;
    if (rdata_valid_o !== exp_v || rdata_tag_o[1*20 +: 20] !== exp_t) begin
      errors++; $display("FAIL collide_same_cycle: valid=%b tag=%h want %b %h", rdata_valid_o, rdata_tag_o[1*20 +: 20], exp_v, exp_t);
    end
    checks++;
    if (rdata_tag_o[3*20 +: 20] !== 20'h33333) begin
      errors++; $display("FAIL collide_other_way: got %h want 33333", rdata_tag_o[3*20 +: 20]);
    end
    do_read(4'd7);
    checks++;
    if (rdata_valid_o !== 4'b1010 || rdata_tag_o[1*20 +: 20] !== 20'h11111) begin
      errors++; $display("FAIL collide_next: valid=%b tag=%h want 1010 11111", rdata_valid_o, rdata_tag_o[1*20 +: 20]);
    end
    // Different sets in the same cycle: read set 4 while writing set 5.
    set_write(4'd5, 2'd0, 1'b1, 20'h55555, '0, 8'd5);
    do_read(4'd4);
    wren_i = 1'b0;
    checks++;
    if (rdata_valid_o !== 4'b0001 || rdata_tag_o[19:0] !== 20'h44444) begin
      errors++; $display("FAIL indep_sets: valid=%b tag=%h want 0001 44444", rdata_valid_o, rdata_tag_o[19:0]);
    end
    do_read(4'd5);
    checks++;
    if (rdata_valid_o !== 4'b0001 || rdata_tag_o[19:0] !== 20'h55555) begin
      errors++; $display("FAIL indep_write: valid=%b tag=%h want 0001 55555", rdata_valid_o, rdata_tag_o[19:0]);
    end
  endtask

  task automatic test_init_write_drop();
    int n;
    pulse_reset();
    repeat (5) @(negedge clk);
    do_write(4'd10, 2'd0, 1'b1, 20'hAAAAA, '1, 8'd7);
    do_read(4'd10);
    checks++;
    if (rdata_valid_o !== 4'b0000 || rdata_tag_o !== '0 || init_busy_o !== 1'b1) begin
      errors++; $display("FAIL init_read: valid=%b tag=%h busy=%b want 0 0 1", rdata_valid_o, rdata_tag_o, init_busy_o);
    end
    wait_ready(n);
    checks++;
    if (n != 9) begin
      errors++; $display("FAIL init_remaining: %0d busy cycles left want 9", n);
    end
    do_read(4'd10);
    checks++;
    if (rdata_valid_o !== 4'b0000) begin
      errors++; $display("FAIL init_write_dropped: got %b want 0000", rdata_valid_o);
    end
  endtask

  task automatic test_reset_mid_traffic();
    int n;
    for (int w = 0; w < 4; w++) do_write(4'd9, 2'(w), 1'b1, 20'h90000 | 20'(w), '1, 8'(w));
    do_read(4'd9);
    checks++;
    if (rdata_valid_o !== 4'b1111 || rdata_tag_o[3*20 +: 20] !== 20'h90003) begin
      errors++; $display("FAIL fill_set9: valid=%b tag3=%h want 1111 90003", rdata_valid_o, rdata_tag_o[3*20 +: 20]);
    end
    rden_i = 1'b1; raddr_i = 4'd9;
    pulse_reset();
    rden_i = 1'b0;
    checks++;
    if (rdata_valid_o !== '0 || rdata_tag_o !== '0 || rdata_data_o !== '0 || rdata_cnt_o !== '0 || init_busy_o !== 1'b1) begin
      errors++; $display("FAIL midreset_clear: valid=%b cnt=%h busy=%b want 0 0 1", rdata_valid_o, rdata_cnt_o, init_busy_o);
    end
    wait_ready(n);
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL midreset_sweep: %0d cycles want 16", n);
    end
    do_read(4'd9);
    checks++;
    if (rdata_valid_o !== 4'b0000) begin
      errors++; $display("FAIL midreset_set9: got %b want 0000", rdata_valid_o);
    end
  endtask

  initial begin
    rst_n = 1'b1; rden_i = 1'b0; raddr_i = '0; wren_i = 1'b0; waddr_i = '0; wway_i = '0;
    wvalid_i = 1'b0; wtag_i = '0; wdata_i = '0; wtype_i = '0; wsyn_i = '0; wcnt_i = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_invalidate();
    test_collision();
    test_init_write_drop();
    test_reset_mid_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
